// File: rtl/dwt_pair_scanner_if.sv
// dwt_pair_scanner_if
//   Bundles the control handshake, the frame RAM read port pair and the
//   outgoing pixel-pair stream of dwt_pair_scanner.
//   Parameters: AW = frame RAM address width, PW = pair/line pointer width.
//   master : the scanner side (drives busy/done, RAM addresses, pair stream)
//   slave  : the environment side (drives start/mode, RAM data, i_ready)
interface dwt_pair_scanner_if #(
  parameter int AW = 16,
  parameter int PW = 8
);
  logic          start;
  logic          mode;
  logic          busy;
  logic          done;
  logic          mem_en;
  logic [AW-1:0] mem_addr_a;
  logic [AW-1:0] mem_addr_b;
  logic [7:0]    mem_data_a;
  logic [7:0]    mem_data_b;
  logic          o_valid;
  logic          i_ready;
  logic [15:0]   pixel_output;
  logic          last_pixel;
  logic [PW-1:0] o_pixel_pointer;
  logic [PW-1:0] o_row_column_pointer;

  modport master (
    input  start, mode, mem_data_a, mem_data_b, i_ready,
    output busy, done, mem_en, mem_addr_a, mem_addr_b,
           o_valid, pixel_output, last_pixel,
           o_pixel_pointer, o_row_column_pointer
  );

  modport slave (
    output start, mode, mem_data_a, mem_data_b, i_ready,
    input  busy, done, mem_en, mem_addr_a, mem_addr_b,
           o_valid, pixel_output, last_pixel,
           o_pixel_pointer, o_row_column_pointer
  );
endinterface

// File: rtl/dwt_pair_scanner.sv
// dwt_pair_scanner
//   Reads an 8-bit HEIGHT x WIDTH image from a dual-port synchronous frame RAM
//   and streams it as {odd,even} pixel pairs, either row by row (mode 0) or
//   column by column (mode 1), tagged with pair index, line index and a
//   last-of-line flag. One pair per cycle when the consumer never stalls.
//   Ports:
//     clk  - rising-edge clock
//     rst  - synchronous active-high reset (abandons a pass, no done pulse)
//     bus  - dwt_pair_scanner_if.master: start/mode/busy/done control,
//            RAM read port (mem_en, mem_addr_a/b, mem_data_a/b), and the
//            valid/ready pair stream with its tags.
//   Pipeline: issue pointer -> RAM data stage (1 cycle) -> output register.
module dwt_pair_scanner #(
  parameter int HEIGHT = 256,
  parameter int WIDTH  = 256
) (
  input logic                clk,
  input logic                rst,
  dwt_pair_scanner_if.master bus
);
  localparam int PW = $clog2(WIDTH);
  localparam int AW = $clog2(HEIGHT * WIDTH);

  localparam logic [PW-1:0] ZERO_PW    = PW'(0);
  localparam logic [PW-1:0] ONE_PW     = PW'(1);
  localparam logic [AW-1:0] ZERO_AW    = AW'(0);
  localparam logic [AW-1:0] ONE_AW     = AW'(1);
  localparam logic [AW-1:0] ROW_STEP   = AW'(2);
  localparam logic [AW-1:0] COL_STEP   = AW'(2 * WIDTH);
  localparam logic [AW-1:0] COL_OFFSET = AW'(WIDTH);

  typedef enum logic [2:0] {
    S_IDLE   = 3'd0,
    S_ISSUE  = 3'd1,
    S_STREAM = 3'd2,
    S_DRAIN  = 3'd3,
    S_DONE   = 3'd4
  } state_t;

  state_t        state_r;
  state_t        state_s;

  logic          mode_r;
  // Issue pointer: the pair whose address goes to the RAM when not stalled
  logic [PW-1:0] iss_k_r;
  logic [PW-1:0] iss_line_r;
  logic [AW-1:0] iss_addr_r;
  // RAM data stage: the pair currently presented on mem_data_a/b
  logic          rd_valid_r;
  logic [PW-1:0] rd_k_r;
  logic [PW-1:0] rd_line_r;
  logic [AW-1:0] rd_addr_r;
  // Output stage
  logic          out_valid_r;
  logic [15:0]   out_pix_r;
  logic          out_last_r;
  logic [PW-1:0] out_k_r;
  logic [PW-1:0] out_line_r;
  // Control flags
  logic          busy_r;
  logic          done_r;
  logic          mem_en_r;

  logic          stall_s;
  logic          advance_s;
  logic          issuing_s;
  logic          iss_final_s;
  logic [PW-1:0] pairs_last_s;
  logic [PW-1:0] lines_last_s;
  logic [AW-1:0] iss_addr_nxt_s;
  logic [AW-1:0] pres_addr_s;
  logic [AW-1:0] b_offset_s;

  // Handshake decode and pass geometry for the latched mode
  always_comb begin
    stall_s   = out_valid_r & ~bus.i_ready;
    advance_s = ~stall_s;
    if (mode_r) begin
      pairs_last_s = PW'(HEIGHT / 2 - 1);
      lines_last_s = PW'(WIDTH - 1);
      b_offset_s   = COL_OFFSET;
    end else begin
      pairs_last_s = PW'(WIDTH / 2 - 1);
      lines_last_s = PW'(HEIGHT - 1);
      b_offset_s   = ONE_AW;
    end
    iss_final_s = (iss_k_r == pairs_last_s) && (iss_line_r == lines_last_s);
    issuing_s   = ((state_r == S_ISSUE) || (state_r == S_STREAM)) && advance_s;
  end

  // Next even-pixel address. A row pass walks memory in steps of two even
  // across line ends; a column pass steps two rows down and restarts at the
  // top of the next column after its last pair.
  always_comb begin
    iss_addr_nxt_s = iss_addr_r + ROW_STEP;
    if (mode_r) begin
      if (iss_k_r == pairs_last_s) begin
        iss_addr_nxt_s = AW'(iss_line_r) + ONE_AW;
      end else begin
        iss_addr_nxt_s = iss_addr_r + COL_STEP;
      end
    end else begin
      iss_addr_nxt_s = iss_addr_r + ROW_STEP;
    end
  end

  // Address presented to the RAM. While the output is stalled the RAM is
  // pointed back at the pair it already holds, so re-reading keeps the data
  // stage aligned with its tags and nothing is lost or repeated.
  always_comb begin
    if (stall_s) begin
      pres_addr_s = rd_addr_r;
    end else begin
      pres_addr_s = iss_addr_r;
    end
  end

  // FSM next-state logic
  always_comb begin
    state_s = state_r;
    case (state_r)
      S_IDLE: begin
        if (bus.start) begin
          state_s = S_ISSUE;
        end else begin
          state_s = S_IDLE;
        end
      end
      S_ISSUE, S_STREAM: begin
        if (issuing_s && iss_final_s) begin
          state_s = S_DRAIN;
        end else if (issuing_s) begin
          state_s = S_STREAM;
        end else begin
          state_s = state_r;
        end
      end
      S_DRAIN: begin
        // The final pair is in the output register once the data stage is empty
        if (out_valid_r && bus.i_ready && !rd_valid_r) begin
          state_s = S_DONE;
        end else begin
          state_s = S_DRAIN;
        end
      end
      S_DONE: begin
        state_s = S_IDLE;
      end
      default: begin
        state_s = S_IDLE;
      end
    endcase
  end

  // FSM state register and registered control flags
  always_ff @(posedge clk) begin
    if (rst) begin
      state_r  <= S_IDLE;
      busy_r   <= 1'b0;
      done_r   <= 1'b0;
      mem_en_r <= 1'b0;
    end else begin
      state_r  <= state_s;
      busy_r   <= (state_s != S_IDLE);
      done_r   <= (state_s == S_DONE);
      mem_en_r <= (state_s == S_ISSUE) || (state_s == S_STREAM) ||
                  (state_s == S_DRAIN);
    end
  end

  // Issue pointer: cleared and mode latched on an accepted start, then
  // advanced whenever a pair address is consumed by the RAM
  always_ff @(posedge clk) begin
    if (rst) begin
      mode_r     <= 1'b0;
      iss_k_r    <= ZERO_PW;
      iss_line_r <= ZERO_PW;
      iss_addr_r <= ZERO_AW;
    end else if ((state_r == S_IDLE) && bus.start) begin
      mode_r     <= bus.mode;
      iss_k_r    <= ZERO_PW;
      iss_line_r <= ZERO_PW;
      iss_addr_r <= ZERO_AW;
    end else if (issuing_s && !iss_final_s) begin
      iss_addr_r <= iss_addr_nxt_s;
      if (iss_k_r == pairs_last_s) begin
        iss_k_r    <= ZERO_PW;
        iss_line_r <= iss_line_r + ONE_PW;
      end else begin
        iss_k_r    <= iss_k_r + ONE_PW;
      end
    end
  end

  // RAM data stage bookkeeping: which pair the RAM output currently holds
  always_ff @(posedge clk) begin
    if (rst) begin
      rd_valid_r <= 1'b0;
      rd_k_r     <= ZERO_PW;
      rd_line_r  <= ZERO_PW;
      rd_addr_r  <= ZERO_AW;
    end else if (issuing_s) begin
      rd_valid_r <= 1'b1;
      rd_k_r     <= iss_k_r;
      rd_line_r  <= iss_line_r;
      rd_addr_r  <= iss_addr_r;
    end else if (advance_s) begin
      rd_valid_r <= 1'b0;
    end
  end

  // Output register: loads the RAM data with its tags unless stalled
  always_ff @(posedge clk) begin
    if (rst) begin
      out_valid_r <= 1'b0;
      out_pix_r   <= 16'h0000;
      out_last_r  <= 1'b0;
      out_k_r     <= ZERO_PW;
      out_line_r  <= ZERO_PW;
    end else if (advance_s) begin
      out_valid_r <= rd_valid_r;
      if (rd_valid_r) begin
        out_pix_r  <= {bus.mem_data_b, bus.mem_data_a};
        out_last_r <= (rd_k_r == pairs_last_s);
        out_k_r    <= rd_k_r;
        out_line_r <= rd_line_r;
      end
    end
  end

  assign bus.busy                 = busy_r;
  assign bus.done                 = done_r;
  assign bus.mem_en               = mem_en_r;
  assign bus.mem_addr_a           = mem_en_r ? pres_addr_s : ZERO_AW;
  assign bus.mem_addr_b           = mem_en_r ? (pres_addr_s + b_offset_s) : ZERO_AW;
  assign bus.o_valid              = out_valid_r;
  assign bus.pixel_output         = out_pix_r;
  assign bus.last_pixel           = out_last_r;
  assign bus.o_pixel_pointer      = out_k_r;
  assign bus.o_row_column_pointer = out_line_r;
endmodule

// File: tb/tb_dwt_pair_scanner.sv
// tb_dwt_pair_scanner
//   Drives a 4x4 scanner through row/column passes, random backpressure,
//   redundant start pulses and a mid-pass reset, and a 256x256 scanner
//   through a full column pass. Accepted pairs are compared against a
//   reference built from the image addressing formulas, plus a table of
//   hand-computed pairs.
module tb_dwt_pair_scanner;
  localparam int SH  = 4;
  localparam int SW  = 4;
  localparam int SAW = 4;
  localparam int SPW = 2;
  localparam int SN  = SH * SW / 2;
  localparam int BH  = 256;
  localparam int BW  = 256;
  localparam int BAW = 16;
  localparam int BPW = 8;
  localparam int BN  = BH * BW / 2;

  typedef struct packed {
    logic [15:0]    pix;
    logic           last;
    logic [SPW-1:0] k;
    logic [SPW-1:0] rc;
  } pair_t;

  typedef struct {
    logic  m;
    int    idx;
    pair_t exp;
  } vec_t;

  logic clk = 1'b0;
  logic rst;
  int   n_total = 0;
  int   n_bad   = 0;
  pair_t got[$];
  vec_t  tbl[8];

  always #5 clk = ~clk;

  dwt_pair_scanner_if #(.AW(SAW), .PW(SPW)) s_if ();
  dwt_pair_scanner_if #(.AW(BAW), .PW(BPW)) b_if ();

  dwt_pair_scanner #(.HEIGHT(SH), .WIDTH(SW)) u_small (
    .clk (clk),
    .rst (rst),
    .bus (s_if.master)
  );

  dwt_pair_scanner #(.HEIGHT(BH), .WIDTH(BW)) u_big (
    .clk (clk),
    .rst (rst),
    .bus (b_if.master)
  );

  // Frame RAMs: small image pix = addr, big image pix = addr mod 256
  always @(posedge clk) begin
    if (s_if.mem_en) begin
      s_if.mem_data_a <= 8'(s_if.mem_addr_a);
      s_if.mem_data_b <= 8'(s_if.mem_addr_b);
    end
    if (b_if.mem_en) begin
      b_if.mem_data_a <= b_if.mem_addr_a[7:0];
      b_if.mem_data_b <= b_if.mem_addr_b[7:0];
    end
  end

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_total++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic fail_now(input string name);
    n_total++;
    n_bad++;
    $display("FAIL %s", name);
  endtask

  // Reference pair idx of a 4x4 pass, straight from the addressing formulas
  function automatic pair_t exp_pair(input logic m, input int idx);
    int pairs, line, k, a, b;
    pair_t p;
    pairs = m ? SH / 2 : SW / 2;
    line  = idx / pairs;
    k     = idx % pairs;
    if (m) begin
      a = 2 * k * SW + line;
      b = a + SW;
    end else begin
      a = line * SW + 2 * k;
      b = a + 1;
    end
    p.pix  = {8'(b), 8'(a)};
    p.last = (k == pairs - 1);
    p.k    = SPW'(k);
    p.rc   = SPW'(line);
    return p;
  endfunction

  function automatic vec_t mk(input logic m, input int idx, input logic [15:0] pix,
                              input logic last, input int k, input int rc);
    vec_t v;
    v.m = m; v.idx = idx;
    v.exp.pix = pix; v.exp.last = last; v.exp.k = SPW'(k); v.exp.rc = SPW'(rc);
    return v;
  endfunction

  task automatic check_table(input logic m);
    for (int i = 0; i < 8; i++) begin
      if (tbl[i].m == m) begin
        if (tbl[i].idx < got.size()) begin
          check($sformatf("tbl_m%0d_pair%0d", m, tbl[i].idx),
                64'(got[tbl[i].idx]), 64'(tbl[i].exp));
        end else begin
          fail_now($sformatf("tbl_m%0d_pair%0d_missing", m, tbl[i].idx));
        end
      end
    end
  endtask

  function automatic logic [63:0] small_outs();
    return 64'({s_if.busy, s_if.done, s_if.mem_en, s_if.mem_addr_a, s_if.mem_addr_b,
                s_if.o_valid, s_if.pixel_output, s_if.last_pixel,
                s_if.o_pixel_pointer, s_if.o_row_column_pointer});
  endfunction

  // One 4x4 pass with i_ready high pct% of cycles; optional redundant start
  // pulses at pass cycles 3 and 5 and random mode changes mid-pass
  task automatic run_pass(input logic m, input int pct, input bit extra_starts,
                          input bit toggle_mode);
    int first_cyc, done_cyc, last_acc, dones, idx;
    bit held_v;
    pair_t held, snap;
    first_cyc = -1; done_cyc = -1; last_acc = -1; dones = 0; idx = 0; held_v = 1'b0;
    held = '0;
    got.delete();
    @(posedge clk); #1;
    s_if.start   = 1'b1;
    s_if.mode    = m;
    s_if.i_ready = ($urandom_range(99) < pct);
    @(posedge clk); #1;
    s_if.start = 1'b0;
    check("busy_after_start", 64'(s_if.busy), 64'd1);
    check("mem_en_issue", 64'(s_if.mem_en), 64'd1);
    check("addr_a_issue", 64'(s_if.mem_addr_a), 64'd0);
    check("addr_b_issue", 64'(s_if.mem_addr_b), m ? 64'(SW) : 64'd1);
    for (int c = 0; c < 200; c++) begin
      @(negedge clk);
      snap.pix = s_if.pixel_output; snap.last = s_if.last_pixel;
      snap.k = s_if.o_pixel_pointer; snap.rc = s_if.o_row_column_pointer;
      if (held_v) check("stall_hold", 64'({s_if.o_valid, snap}), 64'({1'b1, held}));
      held_v = s_if.o_valid && !s_if.i_ready;
      held   = snap;
      if (s_if.o_valid && first_cyc < 0) first_cyc = c;
      if (s_if.o_valid && s_if.i_ready) begin
        if (idx < SN) begin
          check($sformatf("pair%0d_m%0d", idx, m), 64'(snap), 64'(exp_pair(m, idx)));
        end else begin
          fail_now("extra_pair");
        end
        got.push_back(snap);
        idx++;
        last_acc = c;
      end
      if (s_if.done) begin
        dones++;
        if (done_cyc < 0) done_cyc = c;
      end
      if (done_cyc >= 0 && c >= done_cyc + 3) break;
      @(posedge clk); #1;
      s_if.i_ready = ($urandom_range(99) < pct);
      if (toggle_mode) s_if.mode = 1'($urandom);
      s_if.start = extra_starts && (c == 2 || c == 4);
    end
    if (done_cyc < 0) fail_now("done_timeout");
    check("pair_count", 64'(idx), 64'(SN));
    check("done_pulses", 64'(dones), 64'd1);
    check("first_valid_latency", 64'(first_cyc), 64'd2);
    check("done_after_last_accept", 64'(done_cyc), 64'(last_acc + 1));
    if (pct == 100) check("valid_continuous", 64'(last_acc - first_cyc), 64'(SN - 1));
    check("busy_low_after_done", 64'(s_if.busy), 64'd0);
    s_if.start = 1'b0;
  endtask

  initial begin
    int acc, dn, bidx, last_k, last_rc;
    bit hit, bdone;
    int pairs, line, k, a, b;

    tbl[0] = mk(1'b0, 0, 16'h0100, 1'b0, 0, 0);
    tbl[1] = mk(1'b0, 1, 16'h0302, 1'b1, 1, 0);
    tbl[2] = mk(1'b0, 2, 16'h0504, 1'b0, 0, 1);
    tbl[3] = mk(1'b0, 7, 16'h0F0E, 1'b1, 1, 3);
    tbl[4] = mk(1'b1, 0, 16'h0400, 1'b0, 0, 0);
    tbl[5] = mk(1'b1, 1, 16'h0C08, 1'b1, 1, 0);
    tbl[6] = mk(1'b1, 2, 16'h0501, 1'b0, 0, 1);
    tbl[7] = mk(1'b1, 7, 16'h0F0B, 1'b1, 1, 3);

    rst = 1'b1;
    s_if.start = 1'b0; s_if.mode = 1'b0; s_if.i_ready = 1'b0;
    s_if.mem_data_a = 8'h00; s_if.mem_data_b = 8'h00;
    b_if.start = 1'b0; b_if.mode = 1'b0; b_if.i_ready = 1'b0;
    b_if.mem_data_a = 8'h00; b_if.mem_data_b = 8'h00;
    repeat (3) @(posedge clk);
    @(negedge clk);
    check("reset_small_outputs", small_outs(), 64'd0);
    check("reset_big_ctrl", 64'({b_if.busy, b_if.done, b_if.mem_en, b_if.mem_addr_a,
                                 b_if.mem_addr_b, b_if.o_valid}), 64'd0);
    check("reset_big_stream", 64'({b_if.pixel_output, b_if.last_pixel,
                                   b_if.o_pixel_pointer, b_if.o_row_column_pointer}), 64'd0);
    rst = 1'b0;

    // Row pass and column pass, no backpressure
    run_pass(1'b0, 100, 1'b0, 1'b0);
    check_table(1'b0);
    run_pass(1'b1, 100, 1'b0, 1'b0);
    check_table(1'b1);
    // Random backpressure with mode wiggling mid-pass
    run_pass(1'b0, 50, 1'b0, 1'b1);
    check_table(1'b0);
    run_pass(1'b1, 30, 1'b0, 1'b1);
    check_table(1'b1);
    // Redundant start pulses during a pass
    run_pass(1'b0, 100, 1'b1, 1'b0);

    // Reset while pair 5 is on the output
    @(posedge clk); #1;
    s_if.start = 1'b1; s_if.mode = 1'b0; s_if.i_ready = 1'b1;
    @(posedge clk); #1;
    s_if.start = 1'b0;
    acc = 0; hit = 1'b0;
    for (int c = 0; c < 40; c++) begin
      @(negedge clk);
      if (s_if.o_valid && s_if.i_ready) begin
        if (acc == 5) begin
          hit = 1'b1;
          break;
        end
        acc++;
      end
    end
    if (hit) begin
      check("pair5_before_rst", 64'(s_if.pixel_output), 64'h0B0A);
      rst = 1'b1;
      @(posedge clk); #1;
      check("midpass_rst_outputs", small_outs(), 64'd0);
      rst = 1'b0;
      dn = 0;
      for (int c = 0; c < 8; c++) begin
        @(negedge clk);
        if (s_if.done || s_if.o_valid) dn++;
      end
      check("no_activity_after_rst", 64'(dn), 64'd0);
    end else begin
      rst = 1'b0;
      fail_now("pair5_timeout");
    end
    run_pass(1'b0, 100, 1'b0, 1'b0);
    check_table(1'b0);

    // Full 256x256 column pass
    @(posedge clk); #1;
    b_if.start = 1'b1; b_if.mode = 1'b1; b_if.i_ready = 1'b1;
    @(posedge clk); #1;
    b_if.start = 1'b0;
    bidx = 0; bdone = 1'b0; last_k = -1; last_rc = -1;
    pairs = BH / 2;
    for (int c = 0; c < 34000; c++) begin
      @(negedge clk);
      if (b_if.o_valid && b_if.i_ready) begin
        line = bidx / pairs;
        k    = bidx % pairs;
        a    = 2 * k * BW + line;
        b    = a + BW;
        check($sformatf("big_pair%0d", bidx),
              64'({b_if.pixel_output, b_if.last_pixel, b_if.o_pixel_pointer,
                   b_if.o_row_column_pointer}),
              64'({8'(b), 8'(a), (k == pairs - 1), BPW'(k), BPW'(line)}));
        last_k  = int'(b_if.o_pixel_pointer);
        last_rc = int'(b_if.o_row_column_pointer);
        bidx++;
      end
      if (b_if.done) begin
        bdone = 1'b1;
        break;
      end
    end
    if (!bdone) fail_now("big_done_timeout");
    check("big_pair_count", 64'(bidx), 64'(BN));
    check("big_last_k", 64'(last_k), 64'd127);
    check("big_last_rc", 64'(last_rc), 64'd255);

    $display("test done: total=%0d bad=%0d", n_total, n_bad);
    $finish;
  end
endmodule
